lfsr_checker: RTL and testbench

//  Receive-side companion to the Galois LFSR generator: checks an incoming word

---
 rtl/lfsr_checker.sv | 139 +++++++++++++
 tb/tb_lfsr_checker.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_checker.sv
// Receive-side checker for a Galois LFSR word stream.
// Seeds its predictor from received data, confirms lock after SYNC_CNT
// consecutive correct predictions, then free-runs as a flywheel, counting
// mismatched words and dropping lock after LOSS_CNT consecutive misses.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   en         din valid this cycle
//   clr        synchronous clear of err_count
//   din        received LFSR word
//   locked     high while locked
//   err        one-cycle pulse per mismatched word while locked
//   err_count  saturating count of mismatched words while locked
//   expected   predictor register (next word expected)
module lfsr_checker #(
    parameter int unsigned    LEN      = 8,
    parameter logic [LEN-1:0] TAPS     = 8'b10111000,
    parameter int unsigned    SYNC_CNT = 3,
    parameter int unsigned    LOSS_CNT = 4,
    parameter int unsigned    CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [LEN-1:0]   din,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] err_count,
    output logic [LEN-1:0]   expected
);

    localparam int unsigned MATCH_W = $clog2(SYNC_CNT + 1);
    localparam int unsigned MISS_W  = $clog2(LOSS_CNT + 1);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [MATCH_W-1:0] match_cnt, match_nxt;
    logic [MISS_W-1:0]  miss_cnt, miss_nxt;
    logic [LEN-1:0]     expected_nxt;
    logic [CNT_W-1:0]   err_count_nxt;
    logic               err_nxt;
    logic               locked_nxt;

    // One generator step.
    function automatic logic [LEN-1:0] lfsr_step(input logic [LEN-1:0] s);
        return {1'b0, s[LEN-1:1]} ^ (s[0] ? TAPS : LEN'(0));
    endfunction

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_HUNT;
            match_cnt <= '0;
            miss_cnt  <= '0;
            expected  <= '0;
            err       <= 1'b0;
            err_count <= '0;
            locked    <= 1'b0;
        end else begin
            state     <= state_nxt;
            match_cnt <= match_nxt;
            miss_cnt  <= miss_nxt;
            expected  <= expected_nxt;
            err       <= err_nxt;
            err_count <= err_count_nxt;
            locked    <= locked_nxt;
        end
    end

    // Next-state, predictor and error bookkeeping.
    always_comb begin
        state_nxt     = state;
        match_nxt     = match_cnt;
        miss_nxt      = miss_cnt;
        expected_nxt  = expected;
        err_nxt       = 1'b0;
        err_count_nxt = err_count;

        if (en) begin
            case (state)
                ST_HUNT: begin
                    // The all-zero word is the LFSR lockup state; never seed from it.
                    if (din != '0) begin
                        expected_nxt = lfsr_step(din);
                        match_nxt    = '0;
                        state_nxt    = ST_VERIFY;
                    end
                end
                ST_VERIFY: begin
                    if (din == expected) begin
                        expected_nxt = lfsr_step(din);
                        match_nxt    = match_cnt + MATCH_W'(1);
                        if (match_cnt + MATCH_W'(1) == MATCH_W'(SYNC_CNT)) begin
                            state_nxt = ST_LOCKED;
                            miss_nxt  = '0;
                        end
                    end else if (din != '0) begin
                        expected_nxt = lfsr_step(din);
                        match_nxt    = '0;
                    end else begin
                        state_nxt = ST_HUNT;
                    end
                end
                ST_LOCKED: begin
                    // Flywheel: prediction advances from itself, never from din.
                    expected_nxt = lfsr_step(expected);
                    if (din == expected) begin
                        miss_nxt = '0;
                    end else begin
                        err_nxt  = 1'b1;
                        miss_nxt = miss_cnt + MISS_W'(1);
                        if (err_count != {CNT_W{1'b1}}) begin
                            err_count_nxt = err_count + CNT_W'(1);
                        end
                        if (miss_cnt + MISS_W'(1) == MISS_W'(LOSS_CNT)) begin
                            state_nxt = ST_HUNT;
                        end
                    end
                end
                default: state_nxt = ST_HUNT;
            endcase
        end

        // A clear that coincides with a counted error keeps that error.
        if (clr) begin
            err_count_nxt = err_nxt ? CNT_W'(1) : '0;
        end

        locked_nxt = (state_nxt == ST_LOCKED);
    end

endmodule

// File: tb/tb_lfsr_checker.sv
// Bench for lfsr_checker: two instances (default and CNT_W=4/LOSS_CNT=32)
// driven by the same directed word stream, compared every cycle against a
// behavioural model, plus hand-computed literal checks.
module tb_lfsr_checker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        clr = 1'b0;
    logic [7:0]  din = 8'h00;

    logic        a_locked, a_err;
    logic [15:0] a_err_count;
    logic [7:0]  a_expected;
    logic        b_locked, b_err;
    logic [3:0]  b_err_count;
    logic [7:0]  b_expected;

    int checks = 0;
    int fails  = 0;

    lfsr_checker #(.LEN(8), .TAPS(8'hB8), .SYNC_CNT(3), .LOSS_CNT(4), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .din(din),
        .locked(a_locked), .err(a_err), .err_count(a_err_count), .expected(a_expected)
    );

    lfsr_checker #(.LEN(8), .TAPS(8'hB8), .SYNC_CNT(3), .LOSS_CNT(32), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .din(din),
        .locked(b_locked), .err(b_err), .err_count(b_err_count), .expected(b_expected)
    );

    always #5 clk = ~clk;

    // Behavioural model: mode 0 = hunting, 1 = verifying, 2 = locked.
    typedef struct {
        int mode;
        int pred;
        int good;
        int bad;
        int cnt;
        int err;
    } m_t;

    m_t ma = '{0, 0, 0, 0, 0, 0};
    m_t mb = '{0, 0, 0, 0, 0, 0};

    function automatic int fstep(input int s);
        return ((s & 255) >> 1) ^ (((s & 1) != 0) ? 'hB8 : 0);
    endfunction

    function automatic m_t mstep(input m_t m, input bit e, input bit c, input int d,
                                 input int sync, input int loss, input int cmax);
        m_t r = m;
        r.err = 0;
        if (e) begin
            if (r.mode == 0) begin
                if (d != 0) begin
                    r.pred = fstep(d); r.good = 0; r.mode = 1;
                end
            end else if (r.mode == 1) begin
                if (d == r.pred) begin
                    r.pred = fstep(d); r.good++;
                    if (r.good >= sync) begin r.mode = 2; r.bad = 0; end
                end else if (d != 0) begin
                    r.pred = fstep(d); r.good = 0;
                end else begin
                    r.mode = 0;
                end
            end else begin
                if (d == r.pred) begin
                    r.bad = 0;
                end else begin
                    r.err = 1;
                    r.cnt = (r.cnt + 1 > cmax) ? cmax : r.cnt + 1;
                    r.bad++;
                    if (r.bad >= loss) r.mode = 0;
                end
                r.pred = fstep(r.pred);
            end
        end
        if (c) r.cnt = r.err;
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma = '{0, 0, 0, 0, 0, 0};
            mb = '{0, 0, 0, 0, 0, 0};
        end else begin
            ma = mstep(ma, en, clr, int'(din), 3, 4, 65535);
            mb = mstep(mb, en, clr, int'(din), 3, 32, 15);
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        check("model_a_locked", int'(a_locked), (ma.mode == 2) ? 1 : 0);
        check("model_a_err", int'(a_err), ma.err);
        check("model_a_err_count", int'(a_err_count), ma.cnt);
        check("model_a_expected", int'(a_expected), ma.pred);
        check("model_b_locked", int'(b_locked), (mb.mode == 2) ? 1 : 0);
        check("model_b_err", int'(b_err), mb.err);
        check("model_b_err_count", int'(b_err_count), mb.cnt);
        check("model_b_expected", int'(b_expected), mb.pred);
    end

    // One word (or idle cycle); returns just after the edge that consumed it.
    task automatic step(input bit e, input logic [7:0] d, input bit c);
        @(negedge clk);
        en = e; din = d; clr = c;
        @(posedge clk);
        #1;
        en = 1'b0; clr = 1'b0;
    endtask

    task automatic acquire();
        step(1'b1, 8'h01, 1'b0);
        step(1'b1, 8'hB8, 1'b0);
        step(1'b1, 8'h5C, 1'b0);
        step(1'b1, 8'h2E, 1'b0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_locked", int'(a_locked), 0);
        check("rst_expected", int'(a_expected), 0);
        check("rst_err_count", int'(a_err_count), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Lockup word in HUNT, then re-seed inside VERIFY
        step(1'b1, 8'h00, 1'b0);
        check("hunt_zero_locked", int'(a_locked), 0);
        check("hunt_zero_expected", int'(a_expected), 8'h00);
        step(1'b1, 8'h01, 1'b0);
        check("seed_expected", int'(a_expected), 8'hB8);
        step(1'b1, 8'hB8, 1'b0);
        step(1'b1, 8'hFF, 1'b0);
        check("reseed_expected", int'(a_expected), 8'hC7);
        check("reseed_err", int'(a_err), 0);
        check("reseed_locked", int'(a_locked), 0);
        step(1'b1, 8'h00, 1'b0);
        check("verify_zero_locked", int'(a_locked), 0);

        // Acquire with an idle cycle inside
        step(1'b1, 8'h01, 1'b0);
        step(1'b1, 8'hB8, 1'b0);
        step(1'b0, 8'h55, 1'b0);
        check("idle_hold_expected", int'(a_expected), 8'h5C);
        step(1'b1, 8'h5C, 1'b0);
        check("pre_lock_locked", int'(a_locked), 0);
        step(1'b1, 8'h2E, 1'b0);
        check("lock_locked", int'(a_locked), 1);
        check("lock_expected", int'(a_expected), 8'h17);
        step(1'b1, 8'h17, 1'b0);
        check("good_err", int'(a_err), 0);
        check("good_expected", int'(a_expected), 8'hB3);

        // Single error
        step(1'b1, 8'hFF, 1'b0);
        check("error_err", int'(a_err), 1);
        check("error_count", int'(a_err_count), 1);
        check("error_expected", int'(a_expected), 8'hE1);
        step(1'b0, 8'h00, 1'b0);
        check("idle_err", int'(a_err), 0);
        step(1'b1, 8'hE1, 1'b0);
        check("recover_err", int'(a_err), 0);
        check("recover_expected", int'(a_expected), 8'hC8);

        // Three misses then a correct word: stays locked
        for (int i = 0; i < 3; i++) step(1'b1, 8'h00, 1'b0);
        check("three_miss_expected", int'(a_expected), 8'h19);
        step(1'b1, 8'h19, 1'b0);
        check("three_miss_locked", int'(a_locked), 1);
        check("three_miss_count", int'(a_err_count), 4);
        check("three_miss_next", int'(a_expected), 8'hB4);

        // Four consecutive misses drop lock
        for (int i = 0; i < 3; i++) step(1'b1, 8'h00, 1'b0);
        check("loss_3rd_locked", int'(a_locked), 1);
        step(1'b1, 8'h00, 1'b0);
        check("loss_4th_locked", int'(a_locked), 0);
        check("loss_count", int'(a_err_count), 8);
        check("b_still_locked", int'(b_locked), 1);
        check("b_count_8", int'(b_err_count), 8);

        // Clear alone; then saturation on the narrow counter
        step(1'b0, 8'h00, 1'b1);
        check("clr_a_count", int'(a_err_count), 0);
        check("clr_b_count", int'(b_err_count), 0);
        check("clr_b_locked", int'(b_locked), 1);
        for (int i = 0; i < 20; i++) step(1'b1, 8'h00, 1'b0);
        check("sat_b_count", int'(b_err_count), 15);
        check("sat_b_locked", int'(b_locked), 1);
        check("sat_a_count", int'(a_err_count), 0);
        step(1'b1, 8'h00, 1'b1);
        check("clr_err_b_count", int'(b_err_count), 1);
        check("clr_err_b_err", int'(b_err), 1);

        // Async reset mid-lock, then reacquire
        acquire();
        check("relock_a_locked", int'(a_locked), 1);
        step(1'b1, 8'hFF, 1'b0);
        check("prereset_a_count", int'(a_err_count), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_a_locked", int'(a_locked), 0);
        check("async_a_err", int'(a_err), 0);
        check("async_a_count", int'(a_err_count), 0);
        check("async_a_expected", int'(a_expected), 0);
        check("async_b_locked", int'(b_locked), 0);
        check("async_b_count", int'(b_err_count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        acquire();
        check("reacq_a_locked", int'(a_locked), 1);
        check("reacq_b_locked", int'(b_locked), 1);
        check("reacq_a_expected", int'(a_expected), 8'h17);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
